// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - producer and ring_buffer signal bundle for fifo_wr_arbiter
// hi_prio exists only when WR_ARB_PRIORITY_EN is defined.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32
);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int GW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
`ifdef WR_ARB_PRIORITY_EN
    logic [NUM_REQ-1:0]            hi_prio;
`endif
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic [CW-1:0]                 fifo_count;
    logic                          fifo_wr;
    logic [DATA_WIDTH-1:0]         fifo_din;
    logic [GW-1:0]                 grant_id;
    logic                          busy;

    modport master (
`ifdef WR_ARB_PRIORITY_EN
        input  hi_prio,
`endif
        input  req_valid, req_last, req_data, fifo_full, fifo_count,
        output req_ready, fifo_wr, fifo_din, grant_id, busy
    );

    modport slave (
`ifdef WR_ARB_PRIORITY_EN
        output hi_prio,
`endif
        output req_valid, req_last, req_data, fifo_full, fifo_count,
        input  req_ready, fifo_wr, fifo_din, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one ring_buffer write port
// Optional high-priority class selected by WR_ARB_PRIORITY_EN.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_wr_arbiter_if.master bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int CW = $clog2(FIFO_DEPTH);
    localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [GW-1:0]     owner_q, owner_d;
    logic [GW-1:0]     last_grant_q, last_grant_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;

    logic [NUM_REQ-1:0]    cand;
    logic [GW-1:0]         pick;
    logic                  pick_vld;
    logic                  room;
    logic                  accept;
    int                    idx;
    logic [NUM_REQ-1:0]    ready;
    logic                  wr;
    logic [DATA_WIDTH-1:0] din;

    // Admit a burst only if a full MAX_BURST words still fit in the FIFO.
    assign room = ({1'b0, bus.fifo_count} + (CW+1)'(MAX_BURST)) <= (CW+1)'(FIFO_DEPTH - 1);

`ifdef WR_ARB_PRIORITY_EN
    assign cand = (|(bus.req_valid & bus.hi_prio)) ? (bus.req_valid & bus.hi_prio) : bus.req_valid;
`else
    assign cand = bus.req_valid;
`endif

    // Walk offsets downward so the nearest valid index after last_grant wins.
    always_comb begin
        pick     = last_grant_q;
        pick_vld = 1'b0;
        idx      = 0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            idx = (int'(last_grant_q) + i) % NUM_REQ;
            if (cand[idx]) begin
                pick     = GW'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    assign accept = (state_q == BURST) & bus.req_valid[owner_q] & ~bus.fifo_full;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        beat_cnt_d   = beat_cnt_q;
        ready        = '0;
        wr           = 1'b0;
        din          = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld && room) begin
                    owner_d    = pick;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                wr             = accept;
                ready[owner_q] = accept;
                din            = bus.req_data[owner_q*DATA_WIDTH +: DATA_WIDTH];
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // A dropped owner valid releases the port without taking a word.
                if ((accept && (bus.req_last[owner_q] || beat_cnt_q == BW'(MAX_BURST - 1)))
                    || !bus.req_valid[owner_q]) begin
                    state_d      = IDLE;
                    last_grant_d = owner_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            owner_q      <= '0;
            last_grant_q <= GW'(NUM_REQ - 1);
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    assign bus.req_ready = ready;
    assign bus.fifo_wr   = wr;
    assign bus.fifo_din  = din;
    assign bus.grant_id  = owner_q;
    assign bus.busy      = (state_q == BURST);
endmodule
